// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

  // funct3 bit 2 separates the divide family from the multiply family
  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ----------------------------------------------------------------------------
// muldiv_step: one iteration of shift-add multiply or restoring divide.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    hi_next = '0;
    lo_next = '0;
    if (div_mode) begin
      // lo holds the dividend shifting out and the quotient shifting in
      if (!diff[XLEN]) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // {hi,lo} is the accumulator; lo starts as the multiplier
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ----------------------------------------------------------------------------
// muldiv_seq: iterative RV32M multiply/divide unit with valid/ready handshake.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  state_e            state, state_next;
  op_e               op, new_op;
  logic [5:0]        cnt;
  logic              neg_res, neg_rem;
  logic [XLEN-1:0]   hi, lo, opnd;
  logic [XLEN-1:0]   hi_step, lo_step;
  logic              accept, special;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   abs_a, abs_b, special_data, fix_data;
  logic [2*XLEN-1:0] prod;

  assign req_ready = (state == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Request decode: operand magnitudes and early-resolved results
  always_comb begin
    new_op       = op_e'(req_op);
    a_signed     = new_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed     = new_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    sign_a       = a_signed && req_a[XLEN-1];
    sign_b       = b_signed && req_b[XLEN-1];
    abs_a        = sign_a ? ('0 - req_a) : req_a;
    abs_b        = sign_b ? ('0 - req_b) : req_b;
    special      = 1'b0;
    special_data = '0;
    if (is_div(new_op)) begin
      if (req_b == '0) begin
        special      = 1'b1;
        special_data = new_op[1] ? req_a : DIV0_QUOTIENT;
      end else if (b_signed && req_a == SIGNED_MIN && req_b == '1) begin
        special      = 1'b1;
        special_data = new_op[1] ? '0 : SIGNED_MIN;
      end
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode (is_div(op)),
    .hi       (hi),
    .lo       (lo),
    .opnd     (opnd),
    .hi_next  (hi_step),
    .lo_next  (lo_step)
  );

  always_comb begin
    prod     = {hi, lo};
    prod     = neg_res ? ('0 - prod) : prod;
    fix_data = '0;
    unique case (op)
      OP_MUL:                        fix_data = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_data = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_data = neg_res ? ('0 - lo) : lo;
      OP_REM, OP_REMU:               fix_data = neg_rem ? ('0 - hi) : hi;
      default:                       fix_data = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept) state_next = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt == 6'd31) state_next = S_FIXUP;
      S_FIXUP: state_next = S_DONE;
      S_DONE:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= OP_MUL;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      rsp_data <= '0;
    end else if (accept) begin
      op      <= new_op;
      cnt     <= '0;
      neg_res <= sign_a ^ sign_b;
      neg_rem <= sign_a;
      hi      <= '0;
      // divide shifts the dividend through lo; multiply shifts the multiplier
      lo      <= is_div(new_op) ? abs_a : abs_b;
      opnd    <= is_div(new_op) ? abs_b : abs_a;
      if (special) rsp_data <= special_data;
    end else if (state == S_CALC) begin
      hi  <= hi_step;
      lo  <= lo_step;
      cnt <= cnt + 6'd1;
    end else if (state == S_FIXUP) begin
      rsp_data <= fix_data;
    end
  end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage. The ALU handles all one-cycle integer ops. Decode steers M-extension ops to this block, and execute stalls on the valid/ready handshake until the result returns. The block computes one result bit per cycle over 32 iterations, then applies a sign-fixup cycle. Divide-by-zero and signed-overflow cases resolve early.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort of the in-flight op.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; equals (state==IDLE) && !flush.
- req_op  in  3  funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- req_a  in  XLEN  rs1 operand.
- req_b  in  XLEN  rs2 operand.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  XLEN  result.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On req_valid && req_ready, latch op, |a| and |b| (per op signedness), result sign and remainder sign.
  - Clear the 6-bit iteration counter.
  - Go to CALC, or straight to DONE for special cases.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
- CALC, multiply: shift-add into a 64-bit accumulator, one multiplier bit per cycle, 32 cycles.
- CALC, divide: restoring division with a 33-bit partial-remainder subtract, one quotient bit per cycle, 32 cycles.
- FIXUP:
  - Negate product, quotient or remainder as required. Quotient sign is sign(a)^sign(b); remainder takes sign(a).
  - Select the low word (MUL, DIV/DIVU), high word (MULH*), or remainder (REM*).
  - Go to DONE.
- DONE: rsp_valid=1 and rsp_data held stable until rsp_ready=1, then IDLE. req_ready=0 throughout, so there is no overlap of ops.
- Special cases, decided in IDLE with no CALC:
  - b==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - DIV with a=0x80000000, b=0xFFFFFFFF returns 0x80000000; REM returns 0.
- flush: from any state, next state is IDLE. rsp_valid drops the next cycle and no response is produced. A request coincident with flush is not accepted.
- Reset (asynchronous): state IDLE, rsp_valid=0, rsp_data=0, busy=0, all datapath registers 0. req_ready is 1 once rst_n deasserts and flush is low. Reset mid-operation discards the op.

## Timing
- Handshake accepted at edge 0.
- Normal ops: CALC occupies cycles 1–32, FIXUP cycle 33, rsp_valid rises at cycle 34.
- Special cases: rsp_valid rises at cycle 1.
- rsp_data is registered, with no combinational path from req_* to rsp_*.
- Back-to-back ops: next acceptance is at the earliest the cycle after the response handshake. Peak throughput is 1 op per 35 cycles.
- Counter wraps only through the state change: CALC exits when the counter reaches 31.

## Structure
- Package muldiv_pkg holds:
  - the op enum (funct3 encodings above);
  - the state enum;
  - DIV0_QUOTIENT = 0xFFFFFFFF;
  - SIGNED_MIN = 0x80000000.
- Sub-module muldiv_step: the combinational single-iteration datapath. In multiply mode it does a conditional add and shift; in divide mode it does a trial subtract and restore/shift. The top level keeps the FSM, counter, sign latches and output register.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3) -> rsp_data 0xFFFFFFEB at cycle 34. MULH a=b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each must respond at cycle 1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_data stable, req_ready=0 with req_valid held high, then exactly one response handshake.
- Flush at cycle 10 of a DIV -> rsp_valid never rises, busy=0 the next cycle, and a new MUL 3*4 returns 12 with correct latency.
- Assert rst_n=0 mid-CALC -> all outputs reset values immediately, no response after release, and a subsequent op completes normally.
